// File: rtl/write_back_stage.sv
// write_back_stage
//   Final stage of the Y86-64 pipeline. Holds the W pipeline register and
//   drives the register-file write port. A sticky RUN/HALT/FAULT state
//   machine blocks every register write after a non-AOK instruction retires.
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   m_valid .. m_dstM     instruction arriving from the memory stage
//   W_stall, W_bubble     pipeline control (stall has priority over bubble)
//   destE/destM/valE/valM register-file write port (gated indices)
//   w_dstE .. w_icode     raw W contents, used for forwarding
//   cpu_stat, halted      architectural status
//   retire_cnt            count of retired AOK instructions (only when the
//                         WB_RETIRE_CNT_EN macro is defined)
//
// Configuration macro: WB_RETIRE_CNT_EN

module write_back_stage #(
  parameter int unsigned          DATA_WID = 64,
  parameter int unsigned          ADDR_WID = 4,
  parameter logic [ADDR_WID-1:0]  RNONE    = 4'hF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                m_valid,
  input  logic [2:0]          m_stat,
  input  logic [3:0]          m_icode,
  input  logic [DATA_WID-1:0] m_valE,
  input  logic [DATA_WID-1:0] m_valM,
  input  logic [ADDR_WID-1:0] m_dstE,
  input  logic [ADDR_WID-1:0] m_dstM,
  input  logic                W_stall,
  input  logic                W_bubble,
  output logic [ADDR_WID-1:0] destE,
  output logic [ADDR_WID-1:0] destM,
  output logic [DATA_WID-1:0] valE,
  output logic [DATA_WID-1:0] valM,
  output logic [ADDR_WID-1:0] w_dstE,
  output logic [ADDR_WID-1:0] w_dstM,
  output logic [DATA_WID-1:0] w_valE,
  output logic [DATA_WID-1:0] w_valM,
  output logic [3:0]          w_icode,
  output logic [2:0]          cpu_stat,
  output logic                halted
`ifdef WB_RETIRE_CNT_EN
  , output logic [63:0]       retire_cnt
`endif
);

  localparam logic [2:0] STAT_AOK  = 3'd1;
  localparam logic [2:0] STAT_HLT  = 3'd2;
  localparam logic [2:0] STAT_ADR  = 3'd3;
  localparam logic [2:0] STAT_INS  = 3'd4;
  localparam logic [3:0] ICODE_NOP = 4'h1;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_e;

  // W pipeline register
  logic                w_valid_q, w_valid_d;
  logic [2:0]          w_stat_q,  w_stat_d;
  logic [3:0]          w_icode_q, w_icode_d;
  logic [DATA_WID-1:0] w_valE_q,  w_valE_d;
  logic [DATA_WID-1:0] w_valM_q,  w_valM_d;
  logic [ADDR_WID-1:0] w_dstE_q,  w_dstE_d;
  logic [ADDR_WID-1:0] w_dstM_q,  w_dstM_d;

  state_e     state_q;
  logic [2:0] cpu_stat_q;

  logic wr_en;
  logic same_dst;
  logic retire;

  always_comb begin
    w_valid_d = w_valid_q;
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_valE_d  = w_valE_q;
    w_valM_d  = w_valM_q;
    w_dstE_d  = w_dstE_q;
    w_dstM_d  = w_dstM_q;
    if (W_stall) begin
      // hold
    end else if (W_bubble) begin
      w_valid_d = 1'b0;
      w_stat_d  = STAT_AOK;
      w_icode_d = ICODE_NOP;
      w_valE_d  = '0;
      w_valM_d  = '0;
      w_dstE_d  = RNONE;
      w_dstM_d  = RNONE;
    end else begin
      w_valid_d = m_valid;
      w_stat_d  = m_stat;
      w_icode_d = m_icode;
      w_valE_d  = m_valE;
      w_valM_d  = m_valM;
      w_dstE_d  = m_dstE;
      w_dstM_d  = m_dstM;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      w_valid_q <= 1'b0;
      w_stat_q  <= STAT_AOK;
      w_icode_q <= ICODE_NOP;
      w_valE_q  <= '0;
      w_valM_q  <= '0;
      w_dstE_q  <= RNONE;
      w_dstM_q  <= RNONE;
    end else begin
      w_valid_q <= w_valid_d;
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_valE_q  <= w_valE_d;
      w_valM_q  <= w_valM_d;
      w_dstE_q  <= w_dstE_d;
      w_dstM_q  <= w_dstM_d;
    end
  end

  // An instruction leaves W only on an unstalled edge; a stalled one is
  // judged once, when it finally moves on.
  assign retire = w_valid_q && !W_stall && (state_q == S_RUN);

  // Status FSM: HALT and FAULT are sticky; unknown stat codes count as INS.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_RUN;
      cpu_stat_q <= STAT_AOK;
    end else if (retire) begin
      case (w_stat_q)
        STAT_AOK: ;
        STAT_HLT: begin
          state_q    <= S_HALT;
          cpu_stat_q <= STAT_HLT;
        end
        STAT_ADR: begin
          state_q    <= S_FAULT;
          cpu_stat_q <= STAT_ADR;
        end
        default: begin
          state_q    <= S_FAULT;
          cpu_stat_q <= STAT_INS;
        end
      endcase
    end
  end

  // Write gating is combinational on W's own stat, so a faulting
  // instruction never writes even in the cycle it sits in W.
  assign wr_en    = (state_q == S_RUN) && (w_stat_q == STAT_AOK);
  // popq %rsp: both writes target one register, the memory value wins.
  assign same_dst = (w_dstE_q == w_dstM_q) && (w_dstE_q != RNONE);

  assign destE    = (wr_en && !same_dst) ? w_dstE_q : RNONE;
  assign destM    = wr_en ? w_dstM_q : RNONE;
  assign valE     = w_valE_q;
  assign valM     = w_valM_q;

  assign w_dstE   = w_dstE_q;
  assign w_dstM   = w_dstM_q;
  assign w_valE   = w_valE_q;
  assign w_valM   = w_valM_q;
  assign w_icode  = w_icode_q;

  assign cpu_stat = cpu_stat_q;
  assign halted   = (state_q != S_RUN);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      retire_cnt_q <= '0;
    end else if (retire && (w_stat_q == STAT_AOK)) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final pipeline stage of the Y86-64 core and the write-side driver of the register file. Holds the W pipeline register, captures the retiring instruction from the memory stage, and drives the register-file write port (destE/destM/valE/valM), which writes unconditionally on every CLK edge. Tracks architectural status with a sticky RUN/HALT/FAULT state machine that freezes register updates once a non-AOK instruction retires.

## Interface

Parameters:
- DATA_WID, 64, datapath width
- ADDR_WID, 4, register index width
- RNONE, 4'hF, "no register" index; the register file's dummy slot

Ports:
- CLK  input  1  core clock, all state updates on rising edge
- RST_N  input  1  synchronous active-low reset, sampled on rising CLK
- m_valid  input  1  memory stage holds a real instruction
- m_stat  input  3  status: AOK=1, HLT=2, ADR=3, INS=4
- m_icode  input  4  instruction code
- m_valE  input  DATA_WID  ALU result
- m_valM  input  DATA_WID  memory read result
- m_dstE  input  ADDR_WID  destination for valE
- m_dstM  input  ADDR_WID  destination for valM
- W_stall  input  1  hold W register
- W_bubble  input  1  load a bubble into W
- destE, destM  output  ADDR_WID  register-file write indices
- valE, valM  output  DATA_WID  register-file write data
- w_dstE, w_dstM, w_valE, w_valM  output  as above  raw W contents for forwarding
- w_icode  output  4  W icode
- cpu_stat  output  3  architectural status
- halted  output  1  state != RUN

## Operation

- W register fields: valid, stat, icode, valE, valM, dstE, dstM.
- Per edge, priority: !RST_N > W_stall (hold) > W_bubble (valid=0, stat=AOK, icode=1 NOP, dsts=RNONE, vals=0) > load m_* fields.
- W_stall and W_bubble together: stall wins.
- Write gating: destE/destM = w_dstE/w_dstM only when state==RUN and w_stat==AOK; otherwise RNONE. valE/valM always = w_valE/w_valM.
- Same-register conflict: if w_dstE==w_dstM!=RNONE, destE forced to RNONE; valM wins (popq %rsp semantics).
- Stall with a live write: same index/value re-driven each cycle; idempotent, permitted.
- State machine: RUN -> HALT when w_valid, w_stat==HLT, !W_stall; RUN -> FAULT when w_valid, w_stat in {ADR,INS}, !W_stall; HALT and FAULT sticky until reset. Unknown stat codes (0,5-7) treated as INS.
- cpu_stat: AOK in RUN; latched retiring stat in HALT/FAULT.
- Forwarding outputs reflect W contents ungated.

## Timing

- Latency: m_* sampled at edge N appear on W outputs after edge N; register file commits them at edge N+1.
- Non-AOK instruction never writes: gating is combinational on w_stat in the cycle it sits in W.
- Halted state effective from edge following retirement; no later write reaches the register file.
- Reset values: destE=destM=RNONE, valE=valM=0, w_dst*=RNONE, w_val*=0, w_icode=1, cpu_stat=AOK, halted=0, state=RUN, W valid=0.
- Reset mid-operation: one asserted edge restores all above regardless of stall/bubble.

## Configuration

- WB_RETIRE_CNT_EN defined: adds output retire_cnt (64 bits, reset 0), incremented on each edge where W valid, w_stat==AOK, state==RUN, !W_stall; wraps at 2^64-1 to 0.
- Undefined: no port, no counter logic; all other behaviour identical.

## Test plan

- Reset then three loads (dstE=2/valE=0x10, dstM=3/valM=0x20, dstE=4/valE=0x30) -> destE/destM match W one cycle after each capture; retire_cnt=3.
- Load dstE=4, dstM=4, valE=0x1, valM=0x2 -> destE=RNONE, destM=4, valM=0x2.
- Load stat=HLT with dstE=1 -> destE=RNONE that cycle; next edge halted=1, cpu_stat=2; subsequent AOK loads keep destE/destM=RNONE.
- Load stat=ADR, assert W_stall 3 cycles -> state stays RUN, destE=RNONE; release -> cpu_stat=3, halted=1.
- W_stall and W_bubble together with live W dstE=5 -> W held, destE=5; W_bubble alone -> destE=RNONE, w_icode=1.
- In FAULT, drive RST_N=0 one edge -> halted=0, cpu_stat=1, dsts=RNONE, retire_cnt=0.
